// File: rtl/mips_bp_pkg.sv
// Shared types and helpers for the MIPS dynamic branch predictor.
//   mode_e       : pattern-table indexing scheme (bimodal or gshare)
//   btb_entry_t  : one BTB slot (valid, tag, target); the tag field is sized for the
//                  smallest legal table and zero-extended for larger ones
//   sat_inc/dec  : saturating counter steps for counters up to CtrMaxW bits
package mips_bp_pkg;

  typedef enum logic [0:0] {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } mode_e;

  localparam int unsigned TagMaxW = 30;
  localparam int unsigned CtrMaxW = 4;

  typedef struct packed {
    logic               valid;
    logic [TagMaxW-1:0] tag;
    logic [31:0]        target;
  } btb_entry_t;

  // Saturates at 2^bits-1; bits must be 1..CtrMaxW.
  function automatic logic [CtrMaxW-1:0] sat_inc(input logic [CtrMaxW-1:0] v,
                                                 input int unsigned        bits);
    logic [CtrMaxW-1:0] max_v;
    max_v = CtrMaxW'((32'd1 << bits) - 32'd1);
    return (v >= max_v) ? max_v : v + CtrMaxW'(1);
  endfunction

  // Saturates at zero.
  function automatic logic [CtrMaxW-1:0] sat_dec(input logic [CtrMaxW-1:0] v);
    return (v == '0) ? v : v - CtrMaxW'(1);
  endfunction

endpackage

// File: rtl/mips_bp_btb.sv
// Tagged branch target buffer: combinational read, synchronous write.
//   clk_i        core clock
//   rst_ni       synchronous active-low clear of all valid bits
//   rd_idx_i     lookup index (base index of fetch PC)
//   rd_tag_i     lookup tag
//   hit_o        valid entry with matching tag
//   target_o     stored target on hit, 0 otherwise
//   wr_en_i      write the entry at wr_idx_i (overwrites any alias)
//   wr_idx_i     write index
//   wr_tag_i     write tag
//   wr_target_i  write target
module mips_bp_btb
  import mips_bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [$clog2(ENTRIES)-1:0]    rd_idx_i,
  input  logic [29-$clog2(ENTRIES):0]   rd_tag_i,
  output logic                          hit_o,
  output logic [31:0]                   target_o,
  input  logic                          wr_en_i,
  input  logic [$clog2(ENTRIES)-1:0]    wr_idx_i,
  input  logic [29-$clog2(ENTRIES):0]   wr_tag_i,
  input  logic [31:0]                   wr_target_i
);

  btb_entry_t mem_q [ENTRIES];
  btb_entry_t rd_entry;

  assign rd_entry = mem_q[rd_idx_i];
  assign hit_o    = rd_entry.valid && (rd_entry.tag == TagMaxW'(rd_tag_i));
  assign target_o = hit_o ? rd_entry.target : '0;

  // Only the valid bits need clearing; stale tag/target are never observed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem_q[i].valid <= 1'b0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= '{valid: 1'b1, tag: TagMaxW'(wr_tag_i), target: wr_target_i};
    end
  end

endmodule

// File: rtl/mips_branch_predictor.sv
// Dynamic branch predictor for the pipelined MIPS core: a table of saturating
// counters plus a tagged BTB, looked up combinationally in F and trained from
// branch resolution in D. Bimodal or gshare counter indexing.
//   clk, reset (sync, active-low)
//   pc_f                    fetch PC
//   predict_taken_f         BTB hit and counter MSB set
//   predict_target_f        BTB target (0 on miss)
//   btb_hit_f               valid BTB entry with matching tag
//   ghr_f                   global history snapshot, carried down the pipe to D
//   update_*_d              resolved conditional branch in D
//   branch_count            resolved branches (saturating)
//   mispredict_count        mispredictions (saturating)
module mips_branch_predictor
  import mips_bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned MODE      = 0,
  parameter int unsigned GHR_BITS  = 6,
  parameter int unsigned STAT_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          pc_f,
  output logic                 predict_taken_f,
  output logic [31:0]          predict_target_f,
  output logic                 btb_hit_f,
  output logic [GHR_BITS-1:0]  ghr_f,
  input  logic                 update_valid_d,
  input  logic [31:0]          update_pc_d,
  input  logic [GHR_BITS-1:0]  update_ghr_d,
  input  logic                 update_taken_d,
  input  logic [31:0]          update_target_d,
  input  logic                 update_mispred_d,
  output logic [STAT_BITS-1:0] branch_count,
  output logic [STAT_BITS-1:0] mispredict_count
);

  localparam int unsigned IDX  = $clog2(ENTRIES);
  localparam int unsigned TagW = 30 - IDX;
  localparam mode_e       Mode = (MODE == 1) ? BP_GSHARE : BP_BIMODAL;
  // Weakly not-taken.
  localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);

  function automatic logic [IDX-1:0] pat_index(input logic [IDX-1:0]      base,
                                               input logic [GHR_BITS-1:0] ghr);
    if (Mode == BP_GSHARE) begin
      return base ^ IDX'(ghr);
    end
    return base;
  endfunction

  logic [IDX-1:0]       base_f, base_d, pidx_f, pidx_d;
  logic [TagW-1:0]      tag_f, tag_d;
  logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]  ctr_f, ctr_upd;
  logic [GHR_BITS-1:0]  ghr_q, ghr_d, ghr_shift;
  logic [STAT_BITS-1:0] branch_q, branch_d, mispred_q, mispred_d;
  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic                 unused_bits;

  assign base_f = pc_f[IDX+1:2];
  assign tag_f  = pc_f[31:IDX+2];
  assign base_d = update_pc_d[IDX+1:2];
  assign tag_d  = update_pc_d[31:IDX+2];
  assign pidx_f = pat_index(base_f, ghr_q);
  assign pidx_d = pat_index(base_d, update_ghr_d);

  // Byte-offset bits never matter; history is ignored in bimodal mode.
  assign unused_bits = ^{pc_f[1:0], update_pc_d[1:0], update_ghr_d};

  // BTB always uses the plain base index so aliases are resolved by tag only.
  mips_bp_btb #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk_i       (clk),
    .rst_ni      (reset),
    .rd_idx_i    (base_f),
    .rd_tag_i    (tag_f),
    .hit_o       (btb_hit),
    .target_o    (btb_target),
    .wr_en_i     (update_valid_d & update_taken_d),
    .wr_idx_i    (base_d),
    .wr_tag_i    (tag_d),
    .wr_target_i (update_target_d)
  );

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign ctr_f            = ctr_q[pidx_f];
  assign btb_hit_f        = reset & btb_hit;
  assign predict_taken_f  = reset & btb_hit & ctr_f[CTR_BITS-1];
  assign predict_target_f = reset ? btb_target : '0;
  assign ghr_f            = reset ? ghr_q : '0;
  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

  always_comb begin
    logic [CtrMaxW-1:0] cur;
    cur     = CtrMaxW'(ctr_q[pidx_d]);
    ctr_upd = update_taken_d ? CTR_BITS'(sat_inc(cur, CTR_BITS)) : CTR_BITS'(sat_dec(cur));
  end

  if (GHR_BITS == 1) begin : g_ghr_one
    assign ghr_shift = update_taken_d;
  end else begin : g_ghr_multi
    assign ghr_shift = {ghr_q[GHR_BITS-2:0], update_taken_d};
  end

  always_comb begin
    ghr_d     = ghr_q;
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (update_valid_d) begin
      ghr_d = ghr_shift;
      if (!(&branch_q)) begin
        branch_d = branch_q + STAT_BITS'(1);
      end
      if (update_mispred_d && !(&mispred_q)) begin
        mispred_d = mispred_q + STAT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CtrInit;
      end
    end else if (update_valid_d) begin
      ctr_q[pidx_d] <= ctr_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q     <= '0;
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// Bench for mips_branch_predictor: a bimodal instance (dut0) and a gshare instance
// with narrow statistics (dut1) share lookup/update inputs and have separate resets.
// Stimulus pushes expected outputs into a scoreboard; a negedge monitor pops and compares.
module tb_mips_branch_predictor;

  localparam logic [31:0] P0 = 32'h0040_0010;
  localparam logic [31:0] P1 = 32'h0040_0110;
  localparam logic [31:0] P2 = 32'h0040_0200;
  localparam logic [31:0] T0 = 32'h0040_0100;
  localparam logic [31:0] T1 = 32'h0040_0200;

  logic        clk = 1'b0;
  logic        reset0, reset1;
  logic [31:0] pc_f;
  logic        uv, ut, ump;
  logic [31:0] upc, utgt;
  logic [5:0]  ughr;

  logic        tk0, ht0, tk1, ht1;
  logic [31:0] tg0, tg1, br0, mp0;
  logic [5:0]  gh0;
  logic [3:0]  gh1, br1, mp1;

  always #5 clk = ~clk;

  mips_branch_predictor #(
    .ENTRIES (64), .CTR_BITS (2), .MODE (0), .GHR_BITS (6), .STAT_BITS (32)
  ) u_dut0 (
    .clk (clk), .reset (reset0), .pc_f (pc_f),
    .predict_taken_f (tk0), .predict_target_f (tg0), .btb_hit_f (ht0), .ghr_f (gh0),
    .update_valid_d (uv), .update_pc_d (upc), .update_ghr_d (ughr), .update_taken_d (ut),
    .update_target_d (utgt), .update_mispred_d (ump),
    .branch_count (br0), .mispredict_count (mp0)
  );

  mips_branch_predictor #(
    .ENTRIES (64), .CTR_BITS (2), .MODE (1), .GHR_BITS (4), .STAT_BITS (4)
  ) u_dut1 (
    .clk (clk), .reset (reset1), .pc_f (pc_f),
    .predict_taken_f (tk1), .predict_target_f (tg1), .btb_hit_f (ht1), .ghr_f (gh1),
    .update_valid_d (uv), .update_pc_d (upc), .update_ghr_d (ughr[3:0]), .update_taken_d (ut),
    .update_target_d (utgt), .update_mispred_d (ump),
    .branch_count (br1), .mispredict_count (mp1)
  );

  typedef struct packed {
    logic [0:0]  dut;
    logic        tk;
    logic        ht;
    logic [31:0] tg;
    logic        cg;
    logic [5:0]  gh;
    logic        cs;
    logic [31:0] br;
    logic [31:0] mp;
  } exp_t;

  exp_t  sb_q [$];
  string nm_q [$];
  int    n_cmp = 0;
  int    n_fail = 0;
  logic  chk_valid = 1'b0;

  // Monitor: compares one scoreboard entry per flagged cycle, away from the clock edge.
  always @(negedge clk) begin
    if (chk_valid) begin
      exp_t        e;
      string       nm;
      logic        a_tk, a_ht, bad;
      logic [31:0] a_tg, a_br, a_mp;
      logic [5:0]  a_gh;
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry, want one queued");
      end else begin
        e  = sb_q.pop_front();
        nm = nm_q.pop_front();
        if (e.dut == 1'b0) begin
          a_tk = tk0; a_ht = ht0; a_tg = tg0; a_gh = gh0; a_br = br0; a_mp = mp0;
        end else begin
          a_tk = tk1; a_ht = ht1; a_tg = tg1; a_gh = {2'b00, gh1};
          a_br = {28'd0, br1}; a_mp = {28'd0, mp1};
        end
        bad = (a_tk !== e.tk) || (a_ht !== e.ht) || (a_tg !== e.tg) ||
              (e.cg && (a_gh !== e.gh)) || (e.cs && ((a_br !== e.br) || (a_mp !== e.mp)));
        n_cmp++;
        if (bad) begin
          n_fail++;
          $display({"FAIL %s: got taken=%0b hit=%0b target=%h ghr=%h br=%0d mp=%0d; ",
                    "want taken=%0b hit=%0b target=%h ghr=%h(chk %0b) br=%0d mp=%0d(chk %0b)"},
                   nm, a_tk, a_ht, a_tg, a_gh, a_br, a_mp,
                   e.tk, e.ht, e.tg, e.gh, e.cg, e.br, e.mp, e.cs);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
    uv   = 1'b0;
    upc  = 'x;
    ut   = 1'bx;
    utgt = 'x;
    ump  = 1'bx;
    ughr = 'x;
  endtask

  task automatic lookup(input logic [31:0] pc);
    pc_f = pc;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic m, input logic [5:0] g);
    uv = 1'b1; upc = pc; ut = t; utgt = tgt; ump = m; ughr = g;
  endtask

  task automatic chk(input string nm, input logic [0:0] d, input logic tk, input logic ht,
                     input logic [31:0] tg, input logic cg, input logic [5:0] gh,
                     input logic cs, input logic [31:0] br, input logic [31:0] mp);
    exp_t e;
    e = '{dut: d, tk: tk, ht: ht, tg: tg, cg: cg, gh: gh, cs: cs, br: br, mp: mp};
    sb_q.push_back(e);
    nm_q.push_back(nm);
    chk_valid = 1'b1;
  endtask

  // Hand-derived gshare trace for P0 alternating T,N,... starting with T.
  logic [15:0] gs_tk = 16'h5540;
  logic [3:0]  gs_ghr [16] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5,
                               4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5, 4'hA, 4'h5};

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of run, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] br_m, mp_m;
    logic [3:0]  g;
    logic        act;
    reset0 = 1'b0; reset1 = 1'b0;
    pc_f = '0; uv = 1'b0; upc = '0; ut = 1'b0; utgt = '0; ump = 1'b0; ughr = '0;
    @(posedge clk);
    #1;

    // Reset behaviour on the bimodal instance.
    lookup(P0);
    chk("reset_forced", 0, 0, 0, 32'h0, 1, 6'h0, 1, 0, 0); tick();
    reset0 = 1'b1;
    chk("post_reset", 0, 0, 0, 32'h0, 1, 6'h0, 1, 0, 0); tick();

    // First taken training.
    upd(P0, 1, T0, 1, 6'h0);
    chk("miss_before_train", 0, 0, 0, 32'h0, 0, 6'h0, 1, 0, 0); tick();
    chk("first_taken", 0, 1, 1, T0, 0, 6'h0, 1, 1, 1); tick();

    // Saturation then two not-taken.
    repeat (5) begin
      upd(P0, 1, T0, 0, 6'h0); tick();
    end
    upd(P0, 0, 32'h0, 1, 6'h0);
    chk("sat_before_nt", 0, 1, 1, T0, 0, 6'h0, 1, 6, 1); tick();
    upd(P0, 0, 32'h0, 1, 6'h0);
    chk("one_nt_still_taken", 0, 1, 1, T0, 0, 6'h0, 1, 7, 2); tick();
    chk("two_nt_not_taken", 0, 0, 1, T0, 0, 6'h0, 1, 8, 3); tick();

    // Alias on the same base index with a different tag.
    lookup(P1);
    chk("alias_miss", 0, 0, 0, 32'h0, 0, 6'h0, 0, 0, 0); tick();
    upd(P1, 1, T1, 1, 6'h0);
    chk("alias_miss_in_train_cycle", 0, 0, 0, 32'h0, 0, 6'h0, 0, 0, 0); tick();
    chk("alias_trained", 0, 1, 1, T1, 0, 6'h0, 1, 9, 4); tick();
    lookup(P0);
    chk("alias_evicted", 0, 0, 0, 32'h0, 0, 6'h0, 0, 0, 0); tick();

    // Same-cycle update is not bypassed.
    upd(P0, 1, T0, 1, 6'h0);
    chk("same_cycle_old_state", 0, 0, 0, 32'h0, 0, 6'h0, 1, 9, 4); tick();
    chk("same_cycle_next_new", 0, 1, 1, T0, 1, 6'h33, 1, 10, 5); tick();

    // Gshare instance: outputs forced while held in reset.
    chk("dut1_in_reset", 1, 0, 0, 32'h0, 1, 6'h0, 1, 0, 0); tick();
    reset1 = 1'b1;
    tick();

    br_m = 0;
    mp_m = 0;
    for (int k = 0; k < 16; k++) begin
      lookup(P0);
      chk($sformatf("gshare_pred_%0d", k + 1), 1, gs_tk[k], (k != 0), (k != 0) ? T0 : 32'h0,
          1, {2'b00, gs_ghr[k]}, 1, br_m, mp_m);
      tick();
      g   = gh1;  // history loops back from F to D
      act = (k % 2 == 0);
      upd(P0, act, T0, gs_tk[k] != act, {2'b00, g});
      tick();
      if (br_m != 15) br_m++;
      if ((gs_tk[k] != act) && (mp_m != 15)) mp_m++;
    end

    // Drive the narrow statistics into saturation.
    lookup(P2);
    for (int k = 0; k < 14; k++) begin
      upd(P2, 0, 32'h0, 1, 6'h0);
      chk($sformatf("stat_sat_%0d", k), 1, 0, 0, 32'h0, 0, 6'h0, 1, br_m, mp_m);
      tick();
      if (br_m != 15) br_m++;
      if (mp_m != 15) mp_m++;
    end
    chk("stat_sat_final", 1, 0, 0, 32'h0, 0, 6'h0, 1, 15, 15); tick();

    // Reset wins over a simultaneous update and discards history.
    reset1 = 1'b0;
    lookup(P0);
    upd(P0, 1, T0, 1, 6'h0);
    chk("reset_with_update", 1, 0, 0, 32'h0, 1, 6'h0, 0, 0, 0); tick();
    chk("reset_stats_cleared", 1, 0, 0, 32'h0, 1, 6'h0, 1, 0, 0); tick();
    reset1 = 1'b1;
    chk("after_reset_lookup", 1, 0, 0, 32'h0, 1, 6'h0, 1, 0, 0); tick();
    // Counter 5 was trained to 0 before reset; only a weakly-NT reset makes it taken now.
    upd(P0, 1, T0, 0, 6'h1); tick();
    chk("post_reset_retrain", 1, 1, 1, T0, 1, 6'h1, 1, 1, 0); tick();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
